// File: rtl/if_fetch_unit.sv
// if_fetch_unit: MIPS-lite instruction fetch stage with PC, in-flight address queue and output buffer.
module if_fetch_unit #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [WIDTH-1:0] imem_rsp_data,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             stall,
  output logic             inst_valid,
  output logic [WIDTH-1:0] inst_out,
  output logic [WIDTH-1:0] pc_out
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] aq [DEPTH];
  logic [WIDTH-1:0] bpc [DEPTH];
  logic [WIDTH-1:0] binst [DEPTH];
  logic [AW-1:0] aq_wr, aq_rd, b_wr, b_rd;
  logic [CW-1:0] outstanding, drop_cnt, cnt;
  logic pop, credit, fire, rsp_ok, push;
  assign pop = inst_valid & ~stall;
  // Every in-flight request must have a buffer slot reserved for its response.
  assign credit = (CW+1)'(outstanding) + (CW+1)'(cnt) < (CW+1)'(DEPTH) + (CW+1)'(pop);
  assign imem_req_valid = ~rst & ~redirect_valid & credit;
  assign imem_req_addr = rst ? '0 : pc;
  assign fire = imem_req_valid & imem_req_ready;
  assign rsp_ok = imem_rsp_valid & (outstanding != '0);
  assign push = rsp_ok & (drop_cnt == '0) & ~redirect_valid;
  assign inst_valid = cnt != '0;
  assign inst_out = inst_valid ? binst[b_rd] : '0;
  assign pc_out = inst_valid ? bpc[b_rd] : '0;
  always_ff @(posedge clk) begin
    if (fire) aq[aq_wr] <= pc;
    if (push) begin
      bpc[b_wr] <= aq[aq_rd];
      binst[b_wr] <= imem_rsp_data;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
      aq_wr <= '0;
      aq_rd <= '0;
      b_wr <= '0;
      b_rd <= '0;
      outstanding <= '0;
      drop_cnt <= '0;
      cnt <= '0;
    end else begin
      if (fire) aq_wr <= aq_wr + AW'(1);
      if (rsp_ok) aq_rd <= aq_rd + AW'(1);
      outstanding <= outstanding + CW'(fire) - CW'(rsp_ok);
      if (redirect_valid) begin
        pc <= redirect_pc;
        cnt <= '0;
        b_rd <= b_wr;
        drop_cnt <= outstanding - CW'(rsp_ok);
      end else begin
        if (fire) pc <= pc + WIDTH'(4);
        if (push) b_wr <= b_wr + AW'(1);
        if (pop) b_rd <= b_rd + AW'(1);
        cnt <= cnt + CW'(push) - CW'(pop);
        if (rsp_ok && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: random memory/stall/redirect stimulus with a program-order scoreboard plus directed timing checks.
module tb_if_fetch_unit;
  logic clk = 0;
  logic rst = 1;
  logic imem_req_valid, imem_rsp_valid = 0, imem_req_ready = 1;
  logic [31:0] imem_req_addr, imem_rsp_data = 0;
  logic redirect_valid = 0, stall = 0, inst_valid;
  logic [31:0] redirect_pc = 0, inst_out, pc_out;
  int nvec = 0, nerr = 0, consumed = 0;
  bit hold = 0, rnd = 0, ready_low = 0;
  logic [31:0] mq[$];
  logic [31:0] exq[$];
  logic [31:0] nxt = 0, e, a0;
  bit pv_hold = 0, pv_wait = 0;
  logic [31:0] pv_pc, pv_inst, pv_addr;
  int c0;

  if_fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
    .inst_valid(inst_valid), .inst_out(inst_out), .pc_out(pc_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_inst(input string name);
    int n = 0;
    @(negedge clk);
    while (!inst_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!inst_valid) begin
      nvec++;
      nerr++;
      $display("FAIL %s: got no inst_valid expected one within 30 cycles", name);
    end
  endtask

  // Memory: in-order, responds at least one cycle after acceptance
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      imem_rsp_valid = 0;
      imem_rsp_data = 0;
      imem_req_ready = 1;
    end else begin
      if (imem_rsp_valid) void'(mq.pop_front());
      if (imem_req_valid && imem_req_ready) mq.push_back(imem_req_addr);
      #1;
      imem_rsp_valid = mq.size() > 0 && !hold && (!rnd || $urandom_range(99) < 60);
      imem_rsp_data = imem_rsp_valid ? memf(mq[0]) : 32'h0;
      imem_req_ready = !ready_low && (!rnd || $urandom_range(99) < 70);
    end
  end

  // Scoreboard: consumed instructions must be the sequential stream from the last reset/redirect target
  always @(negedge clk) begin
    if (rst) begin
      exq.delete();
      nxt = 32'h0;
      pv_hold = 0;
      pv_wait = 0;
    end else begin
      if (pv_hold) begin
        chk("stall_valid", inst_valid, 1);
        chk("stall_pc", pc_out, pv_pc);
        chk("stall_inst", inst_out, pv_inst);
      end
      if (pv_wait && !redirect_valid) begin
        chk("req_hold_valid", imem_req_valid, 1);
        chk("req_hold_addr", imem_req_addr, pv_addr);
      end
      if (redirect_valid) begin
        exq.delete();
        nxt = redirect_pc;
      end
      while (exq.size() < 8) begin
        exq.push_back(nxt);
        nxt = nxt + 4;
      end
      if (!redirect_valid && inst_valid && !stall) begin
        e = exq.pop_front();
        chk("pop_pc", pc_out, e);
        chk("pop_inst", inst_out, memf(e));
        consumed++;
      end
      pv_hold = inst_valid && stall && !redirect_valid;
      pv_pc = pc_out;
      pv_inst = inst_out;
      pv_wait = imem_req_valid && !imem_req_ready;
      pv_addr = imem_req_addr;
    end
  end

  initial begin
    @(posedge clk); #2;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_req_addr", imem_req_addr, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst_out", inst_out, 0);
    chk("rst_pc_out", pc_out, 0);
    @(posedge clk); #2 rst = 0;
    @(negedge clk);
    chk("seq_req_valid", imem_req_valid, 1);
    chk("seq_addr0", imem_req_addr, 32'h0);
    chk("seq_early_valid", inst_valid, 0);
    @(negedge clk);
    chk("seq_addr1", imem_req_addr, 32'h4);
    chk("seq_latency_valid", inst_valid, 0);
    @(negedge clk);
    chk("seq_first_valid", inst_valid, 1);
    chk("seq_pc0", pc_out, 32'h0);
    @(negedge clk);
    chk("seq_pc4", pc_out, 32'h4);
    @(posedge clk); #2 stall = 1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_head_pc", pc_out, 32'h8);
      chk("stall_head_inst", inst_out, memf(32'h8));
      chk("stall_full_no_req", imem_req_valid, 0);
    end
    @(posedge clk); #2 stall = 0;
    @(negedge clk);
    chk("unstall_pc8", pc_out, 32'h8);
    @(negedge clk);
    chk("unstall_pcc", pc_out, 32'hc);
    ready_low = 1;
    @(negedge clk);
    a0 = imem_req_addr;
    chk("bp_addr", a0, 32'h18);
    chk("bp_valid", imem_req_valid, 1);
    repeat (3) begin
      @(negedge clk);
      chk("bp_hold_addr", imem_req_addr, a0);
      chk("bp_hold_valid", imem_req_valid, 1);
    end
    ready_low = 0;
    @(negedge clk);
    chk("bp_release_addr", imem_req_addr, a0);
    @(negedge clk);
    chk("bp_advance_addr", imem_req_addr, a0 + 4);
    hold = 1;
    repeat (4) @(negedge clk);
    chk("inflight_limit", imem_req_valid, 0);
    @(posedge clk); #2 redirect_valid = 1; redirect_pc = 32'h100;
    @(negedge clk);
    chk("redir_no_req", imem_req_valid, 0);
    @(posedge clk); #2 redirect_valid = 0; hold = 0;
    wait_inst("redir1_wait");
    chk("redir1_pc", pc_out, 32'h100);
    chk("redir1_inst", inst_out, memf(32'h100));
    repeat (6) @(negedge clk);
    @(posedge clk); #2 stall = 1;
    repeat (4) @(negedge clk);
    @(posedge clk); #2 redirect_valid = 1; redirect_pc = 32'h180;
    @(negedge clk);
    chk("flush_pre_valid", inst_valid, 1);
    chk("flush_no_req", imem_req_valid, 0);
    @(posedge clk); #2 redirect_valid = 0; stall = 0;
    @(negedge clk);
    chk("flush_empty", inst_valid, 0);
    chk("flush_req_valid", imem_req_valid, 1);
    chk("flush_req_addr", imem_req_addr, 32'h180);
    @(negedge clk);
    @(negedge clk);
    chk("flush_new_pc", pc_out, 32'h180);
    repeat (6) @(negedge clk);
    begin
      int n = 0;
      @(posedge clk); #2;
      while (!imem_rsp_valid && n < 20) begin
        @(posedge clk); #2;
        n++;
      end
      chk("coinc_rsp_seen", imem_rsp_valid, 1);
    end
    redirect_valid = 1; redirect_pc = 32'h200;
    @(posedge clk); #2 redirect_valid = 0;
    @(negedge clk);
    chk("coinc_req_addr", imem_req_addr, 32'h200);
    chk("coinc_req_valid", imem_req_valid, 1);
    chk("coinc_empty1", inst_valid, 0);
    @(negedge clk);
    chk("coinc_empty2", inst_valid, 0);
    @(negedge clk);
    chk("coinc_valid", inst_valid, 1);
    chk("coinc_pc", pc_out, 32'h200);
    hold = 1;
    repeat (4) @(negedge clk);
    #2 rst = 1;
    #1;
    chk("arst_req_valid", imem_req_valid, 0);
    chk("arst_req_addr", imem_req_addr, 0);
    chk("arst_inst_valid", inst_valid, 0);
    chk("arst_inst_out", inst_out, 0);
    chk("arst_pc_out", pc_out, 0);
    @(posedge clk); #2 hold = 0;
    @(posedge clk); #2 rst = 0;
    @(negedge clk);
    chk("arst_restart_valid", imem_req_valid, 1);
    chk("arst_restart_addr", imem_req_addr, 32'h0);
    wait_inst("arst_wait");
    chk("arst_first_pc", pc_out, 32'h0);
    c0 = consumed;
    rnd = 1;
    repeat (3000) begin
      @(posedge clk); #2;
      redirect_valid = !redirect_valid && $urandom_range(99) < 3;
      redirect_pc = ($urandom_range(3) == 0) ? 32'hffff_fff8 : ($urandom & 32'hffff_fffc);
      stall = $urandom_range(99) < 30;
    end
    @(posedge clk); #2 redirect_valid = 0; stall = 0; rnd = 0;
    repeat (10) @(negedge clk);
    chk("rand_progress", (consumed - c0) > 300, 1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction fetch stage of the MIPS-lite pipeline. It owns the program counter and issues word fetches to instruction memory over a valid/ready request channel, accepting in-order responses. It buffers fetched instructions with their PCs and presents them to the IF/ID pipeline register. Downstream stalls and branch/jump redirects are honoured without losing or duplicating instructions.

## Interface
- `WIDTH`, 32: instruction, address and PC width.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `DEPTH`, 2: output buffer entries, which also sets the maximum number of in-flight requests (power of two, ≥2).

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_req_addr`  out  WIDTH  word address of the request; equals the current PC.
- `imem_rsp_valid`  in  1  response valid; responses return in request order, at least 1 cycle after acceptance.
- `imem_rsp_data`  in  WIDTH  fetched instruction.
- `redirect_valid`  in  1  branch/jump taken; 1-cycle pulse.
- `redirect_pc`  in  WIDTH  new fetch address.
- `stall`  in  1  downstream cannot take an instruction this cycle.
- `inst_valid`  out  1  `inst_out` and `pc_out` hold a valid instruction.
- `inst_out`  out  WIDTH  instruction sent to IF/ID.
- `pc_out`  out  WIDTH  PC of `inst_out`.

## Operation
- **State**
  - `pc` register.
  - In-flight address queue of DEPTH entries.
  - Output buffer of DEPTH {pc, instr} entries (circular, wrap-around pointers).
  - `outstanding` counter (0..DEPTH) and `drop_cnt` counter (0..DEPTH).
- **Pop:** `pop = inst_valid & !stall`. The buffer head is consumed on the edge.
- **Credit:** `outstanding + occupancy - pop < DEPTH`.
- **Request:** `imem_req_valid = !rst & !redirect_valid & credit`.
  - On handshake (valid & ready): the address is pushed to the in-flight queue, `outstanding` increments, and `pc <= pc + 4` (modulo 2^WIDTH; wraps silently).
  - While ready is low: valid stays high and the address stays stable until accepted or a redirect occurs.
- **Response:** `imem_rsp_valid` pops the in-flight queue and decrements `outstanding`.
  - If `drop_cnt != 0` or `redirect_valid` is high, the response is discarded, decrementing `drop_cnt` only if it is non-zero.
  - Otherwise {queued address, data} is pushed to the output buffer.
  - A response received while `outstanding == 0` is ignored (protocol violation).
- **Redirect (on the edge with `redirect_valid`)**
  - `pc <= redirect_pc`.
  - The output buffer is emptied, including the entry that would have been popped this cycle.
  - `drop_cnt <= outstanding - (imem_rsp_valid ? 1 : 0)`, i.e. all in-flight responses not arriving this cycle are dropped later.
  - No request is issued in the redirect cycle.
- **Outputs**
  - `inst_valid` = buffer non-empty.
  - `inst_out`/`pc_out` = buffer head, or 0 (NOP) when empty.
  - Head values remain stable while `stall` is high.
- **Simultaneous events**
  - Push and pop in the same cycle are both performed.
  - Redirect overrides any push and pop.
  - Redirect has priority over a stall.
- **Reset**
  - Asynchronous assertion at any time, including mid-operation with requests in flight: `pc = RESET_PC`; queues empty; `outstanding = drop_cnt = 0`.
  - All outputs are 0 while `rst` is high; `imem_req_addr` shows RESET_PC only after release.
  - Responses to pre-reset requests arriving after release are treated as protocol violations; memory is reset alongside this unit.

## Timing
- **Reset release:** `imem_req_valid` rises in the first cycle after `rst` deasserts, with address RESET_PC.
- **Latency:** with 1-cycle memory, request accepted at edge T → response visible in cycle T+1 → `inst_valid` in cycle T+2 (registered buffer, no response bypass).
- **Throughput:** 1 instruction/cycle sustained with DEPTH=2 and 1-cycle memory, `stall` low and `imem_req_ready` high.
- **Redirect:** issued in cycle R → first request to `redirect_pc` in cycle R+1 → its instruction valid no earlier than R+3.
- **Stall:** `inst_valid` stays high and the head is unchanged while `stall` is high. Fetch continues until credit is exhausted (buffer full), then `imem_req_valid` drops.

## Test plan
- **Sequential fetch:** reset, 1-cycle memory, no stall → requests 0x0, 0x4, 0x8… on consecutive cycles; `pc_out` 0x0 first valid 2 cycles after the first request, then one instruction per cycle in order.
- **Stall:** `stall` held 3 cycles while the head is at 0x8 → `inst_out`/`pc_out` hold 0x8 throughout; at most DEPTH entries buffered; `imem_req_valid` drops when full; 0xC follows on release, with no loss or duplication.
- **Memory back-pressure:** `imem_req_ready` low 4 cycles → `imem_req_addr` stable, `pc` not advanced, no request lost.
- **Redirect with 2 in flight:** `redirect_pc = 0x100` → both stale responses discarded; next valid `pc_out` is 0x100; buffer flushed in the same cycle.
- **Redirect coincident with a response:** that response is discarded and `drop_cnt` = outstanding − 1; no stale instruction appears.
- **Mid-run reset:** assert `rst` asynchronously between clock edges with 2 requests in flight → all outputs immediately 0; after release, fetch restarts at RESET_PC.
